mult_digit_seq: RTL and testbench

- Iterative unsigned multiplier controller that sequences a single 2x2 partial-product unit across all 2-bit digit pairs of two WIDTH-bit operands.
- Accumulates the shifted partial products into a 2*WIDTH-bit product.
- Sits between a valid/ready producer and consumer where area matters more than throughput.
- The 2x2 unit is instantiated internally and computes the full 4-bit product of two 2-bit digits.

---
 rtl/mult_digit_seq.sv | 145 ++++++++++++++
 tb/tb_mult_digit_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_digit_seq.sv
// Purpose  : iterative unsigned WIDTH x WIDTH multiplier built from one 2x2 digit multiplier.
// Latency  : D*D cycles in CALC, then the product is presented in DONE (accept edge counts as edge 1,
//            so out_valid is seen D*D+1 edges later); initiation interval D*D+2.
// Backpress: product is held in DONE until out_ready; inputs are not accepted outside IDLE.
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b accepted in IDLE)
//   a, b                 WIDTH-bit unsigned operands
//   out_valid/out_ready  product handshake
//   product              2*WIDTH-bit unsigned a*b, holds last value outside DONE
//   busy                 high while an operation is in CALC or DONE
//
// WIDTH must be even and >= 2.

// 2-bit x 2-bit unsigned multiplier producing the full 4-bit product.
module mult_digit_mul2x2 (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic [3:0] p
);
   assign p = {2'b00, x} * {2'b00, y};
endmodule

module mult_digit_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);
   localparam int D  = WIDTH / 2;
   localparam int IW = (D > 1) ? $clog2(D) : 1;
   localparam int PW = 2 * WIDTH;

   localparam logic [IW-1:0] LAST = IW'(D - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    prod_q;
   logic [IW-1:0]    i;
   logic [IW-1:0]    j;

   logic [1:0]       a_dig;
   logic [1:0]       b_dig;
   logic [3:0]       pp;
   logic [PW-1:0]    pp_ext;
   logic [IW:0]      dig_sum;
   logic [IW+1:0]    shamt;
   logic [PW-1:0]    acc_nxt;

   // Current digit pair; i walks the multiplicand, j the multiplier.
   assign a_dig = a_q[int'(i) * 2 +: 2];
   assign b_dig = b_q[int'(j) * 2 +: 2];

   mult_digit_mul2x2 u_mul (
      .x (a_dig),
      .y (b_dig),
      .p (pp)
   );

   // Digit weight is 4^(i+j), i.e. a left shift of 2*(i+j) bits.
   assign dig_sum = {1'b0, i} + {1'b0, j};
   assign shamt   = {dig_sum, 1'b0};

   always_comb begin
      pp_ext      = '0;
      pp_ext[3:0] = pp;
   end

   // The running sum is bounded by (2^WIDTH-1)^2, so it never wraps.
   assign acc_nxt = acc + (pp_ext << shamt);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         acc    <= '0;
         prod_q <= '0;
         i      <= '0;
         j      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  acc   <= '0;
                  i     <= '0;
                  j     <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               acc <= acc_nxt;
               if (j == LAST) begin
                  j <= '0;
                  if (i == LAST) begin
                     // Final digit pair: publish the completed sum directly so the
                     // product register is valid on entry to DONE.
                     i      <= '0;
                     prod_q <= acc_nxt;
                     state  <= DONE;
                  end else begin
                     i <= i + IW'(1);
                  end
               end else begin
                  j <= j + IW'(1);
               end
            end
            DONE: begin
               // in_valid is deliberately not looked at here, even on the
               // handshake edge; a new operand waits for the IDLE cycle.
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // All outputs come from registers or from the state encoding alone.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign product   = prod_q;

endmodule

// File: tb/tb_mult_digit_seq.sv
module tb_mult_digit_seq;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] product8;

   logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
   logic [1:0]  a2, b2;
   logic [3:0]  product2;

   int npass  = 0;
   int nfail  = 0;
   int ntotal = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mult_digit_seq #(.WIDTH(8)) u_w8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .product   (product8),
      .busy      (busy8)
   );

   mult_digit_seq #(.WIDTH(2)) u_w2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid2),
      .in_ready  (in_ready2),
      .a         (a2),
      .b         (b2),
      .out_valid (out_valid2),
      .out_ready (out_ready2),
      .product   (product2),
      .busy      (busy2)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Accepts one operand pair on the WIDTH=8 unit (out_ready8 must be 1) and
   // checks busy, latency (accepting edge counted as edge 1), product and return to IDLE.
   task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [15:0] exp);
      int n;
      a8 = av;
      b8 = bv;
      in_valid8 = 1'b1;
      tick;
      in_valid8 = 1'b0;
      chk({tag, "_busy"}, 32'(busy8), 1);
      chk({tag, "_in_ready_calc"}, 32'(in_ready8), 0);
      n = 1;
      while (!out_valid8 && n < 40) begin
         tick;
         n++;
      end
      chk({tag, "_latency"}, n, 17);
      chk({tag, "_product"}, 32'(product8), 32'(exp));
      tick;
      chk({tag, "_out_valid_drop"}, 32'(out_valid8), 0);
      chk({tag, "_in_ready_idle"}, 32'(in_ready8), 1);
      chk({tag, "_product_kept"}, 32'(product8), 32'(exp));
   endtask

   initial begin
      int n;
      int last_acc;
      logic seen;

      rst_n      = 1'b0;
      in_valid8  = 1'b0;
      out_ready8 = 1'b1;
      a8         = 8'd0;
      b8         = 8'd0;
      in_valid2  = 1'b0;
      out_ready2 = 1'b1;
      a2         = 2'd0;
      b2         = 2'd0;

      // Reset held two cycles, then released.
      tick;
      tick;
      rst_n = 1'b1;
      tick;
      chk("rst_in_ready",  32'(in_ready8),  1);
      chk("rst_out_valid", 32'(out_valid8), 0);
      chk("rst_product",   32'(product8),   0);
      chk("rst_busy",      32'(busy8),      0);
      chk("rst_w2_in_ready", 32'(in_ready2), 1);
      chk("rst_w2_product",  32'(product2),  0);

      // Basic products.
      run8("p3x2",    8'd3,   8'd2,   16'd6);
      run8("p255x255", 8'd255, 8'd255, 16'hFE01);
      run8("p0x200",  8'd0,   8'd200, 16'd0);

      // Output backpressure with a different operand pending on in_valid.
      out_ready8 = 1'b0;
      a8 = 8'd170;
      b8 = 8'd85;
      in_valid8 = 1'b1;
      tick;
      a8 = 8'd7;
      b8 = 8'd9;
      n = 1;
      while (!out_valid8 && n < 40) begin
         tick;
         n++;
      end
      chk("bp_latency", n, 17);
      for (int c = 0; c < 10; c++) begin
         chk("bp_product_held", 32'(product8),   14450);
         chk("bp_in_ready",     32'(in_ready8),  0);
         chk("bp_out_valid",    32'(out_valid8), 1);
         tick;
      end
      // Handshake edge: in_valid=1 must not start a new operation here.
      out_ready8 = 1'b1;
      tick;
      chk("bp_handshake_idle", 32'(in_ready8), 1);
      chk("bp_handshake_busy", 32'(busy8),     0);
      chk("bp_handshake_drop", 32'(out_valid8), 0);
      tick;
      in_valid8 = 1'b0;
      chk("bp_second_accepted", 32'(busy8), 1);
      n = 1;
      while (!out_valid8 && n < 40) begin
         tick;
         n++;
      end
      chk("bp_second_latency", n, 17);
      chk("bp_second_product", 32'(product8), 63);
      tick;

      // Reset during the 5th CALC cycle aborts the operation.
      a8 = 8'd100;
      b8 = 8'd100;
      in_valid8 = 1'b1;
      tick;
      in_valid8 = 1'b0;
      tick;
      tick;
      tick;
      tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("abort_in_ready",  32'(in_ready8),  1);
      chk("abort_busy",      32'(busy8),      0);
      chk("abort_out_valid", 32'(out_valid8), 0);
      chk("abort_product",   32'(product8),   0);
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (out_valid8) seen = 1'b1;
         tick;
      end
      chk("abort_no_output", 32'(seen), 0);
      run8("p12x13", 8'd12, 8'd13, 16'd156);

      // WIDTH=2: all 16 combinations back-to-back with in_valid held high.
      in_valid2 = 1'b1;
      last_acc = 0;
      for (int k = 0; k < 16; k++) begin
         a2 = 2'(k >> 2);
         b2 = 2'(k & 3);
         chk("w2_in_ready", 32'(in_ready2), 1);
         tick;
         if (k > 0) chk("w2_interval", cyc - last_acc, 3);
         last_acc = cyc;
         chk("w2_calc_no_valid", 32'(out_valid2), 0);
         tick;
         chk("w2_valid_at_2", 32'(out_valid2), 1);
         chk("w2_product", 32'(product2), (k >> 2) * (k & 3));
         tick;
      end
      in_valid2 = 1'b0;

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
